ps2_rx_fifo: RTL and testbench

PS/2 device-to-host receiver with byte FIFO. Feeds the keyboard matrix mapper.
- Samples ps2_clk/ps2_dat, deframes 11-bit frames and checks start, parity and stop bits.
- Queues good bytes and presents them through a pop handshake (rden/q/dsr).
- Sits directly upstream of the scancode-to-matrix logic; shares the PS/2 lines with the transmitter.

---
 rtl/ps2_rx_fifo.sv | 167 ++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: deframes 11-bit frames into a byte FIFO.
// Optional ps2_clk stability filter: define PS2RX_GLITCH_FILTER_EN.
module ps2_rx_fifo #(
    parameter int FIFO_AW        = 3,
    parameter int TIMEOUT_CYCLES = 24000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    inout  wire        ps2_clk,
    inout  wire        ps2_dat,
    input  logic       samplen,
    input  logic       rden,
    output logic [7:0] q,
    output logic       dsr,
    output logic       overflow,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t     state;
    logic [2:0] bitcnt;
    logic [7:0] shreg;
    logic       par;
    logic       push;
    logic [TW-1:0] tcnt;

    logic c_s1, c_s2, d_s1, d_s2, c_prev, clk_lvl, fall;

    // Lines are only sampled here; the transmitter owns any drive.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_s1 <= 1'b1;
            c_s2 <= 1'b1;
            d_s1 <= 1'b1;
            d_s2 <= 1'b1;
        end else begin
            c_s1 <= ps2_clk;
            c_s2 <= c_s1;
            d_s1 <= ps2_dat;
            d_s2 <= d_s1;
        end
    end

`ifdef PS2RX_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN + 1);
    logic [FW-1:0] fcnt;
    logic          c_filt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fcnt   <= '0;
            c_filt <= 1'b1;
        end else if (c_s2 != c_filt) begin
            if (fcnt == FW'(FILTER_LEN - 1)) begin
                fcnt   <= '0;
                c_filt <= c_s2;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end else begin
            fcnt <= '0;
        end
    end

    assign clk_lvl = c_filt;
`else
    logic unused_filter;
    assign unused_filter = (FILTER_LEN > 0);
    assign clk_lvl = c_s2;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) c_prev <= 1'b1;
        else          c_prev <= clk_lvl;
    end

    assign fall = c_prev & ~clk_lvl & samplen;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            bitcnt    <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            push      <= 1'b0;
            frame_err <= 1'b0;
            tcnt      <= '0;
        end else begin
            push      <= 1'b0;
            frame_err <= 1'b0;
            if (!samplen) begin
                state <= IDLE;
                tcnt  <= '0;
            end else if (state == IDLE) begin
                tcnt <= '0;
                if (fall) begin
                    if (!d_s2) begin
                        state  <= DATA;
                        bitcnt <= '0;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
            end else if (fall) begin
                tcnt <= '0;
                case (state)
                    DATA: begin
                        shreg  <= {d_s2, shreg[7:1]};
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par   <= d_s2;
                        state <= STOP;
                    end
                    default: begin
                        if (d_s2 && (^shreg ^ par)) push <= 1'b1;
                        else                        frame_err <= 1'b1;
                        state <= IDLE;
                    end
                endcase
            end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                frame_err <= 1'b1;
                state     <= IDLE;
                tcnt      <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    logic [7:0]       mem [2**FIFO_AW];
    logic [FIFO_AW:0] wptr, rptr, wptr_n, rptr_n;
    logic             empty, full, rd, wr;

    assign empty  = (wptr == rptr);
    assign full   = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                    (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
    assign rd     = rden & ~empty;
    // A simultaneous pop frees the slot the push needs.
    assign wr     = push & (~full | rd);
    assign wptr_n = wptr + (FIFO_AW+1)'(wr);
    assign rptr_n = rptr + (FIFO_AW+1)'(rd);

    always_ff @(posedge clk) begin
        if (wr) mem[wptr[FIFO_AW-1:0]] <= shreg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr     <= '0;
            rptr     <= '0;
            q        <= '0;
            dsr      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wptr <= wptr_n;
            rptr <= rptr_n;
            dsr  <= (wptr_n != rptr_n);
            if (rd) q <= mem[rptr[FIFO_AW-1:0]];
            if (push && !wr) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frames driven on the PS/2 lines,
// popped bytes and status flags compared with hand-computed values.
module tb_ps2_rx_fifo;
    localparam int TO = 200;
    localparam int HP = 20;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       c_drv = 1'b1;
    logic       d_drv = 1'b1;
    logic       samplen = 1'b1;
    logic       rden = 1'b0;
    logic [7:0] q;
    logic       dsr, overflow, frame_err;
    wire        ps2_c, ps2_d;
    int         passed = 0;
    int         total = 0;
    int         ferr_cnt = 0;
    int         ferr_base;

    assign ps2_c = c_drv;
    assign ps2_d = d_drv;

    ps2_rx_fifo #(
        .FIFO_AW(3),
        .TIMEOUT_CYCLES(TO),
        .FILTER_LEN(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .ps2_clk(ps2_c),
        .ps2_dat(ps2_d),
        .samplen(samplen),
        .rden(rden),
        .q(q),
        .dsr(dsr),
        .overflow(overflow),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_err) ferr_cnt++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // nbits < 11 sends a truncated frame (start bit first)
    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              input int nbits);
        logic [10:0] f;
        f = {1'b1, ~^b ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            d_drv = f[i];
            repeat (HP/2) @(posedge clk);
            c_drv = 1'b0;
            repeat (HP) @(posedge clk);
            c_drv = 1'b1;
            repeat (HP/2) @(posedge clk);
        end
        d_drv = 1'b1;
        repeat (40) @(posedge clk);
    endtask

    task automatic pop();
        @(negedge clk) rden = 1'b1;
        @(negedge clk) rden = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_q", q, 8'h00);
        chk("rst_dsr", dsr, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ferr", frame_err, 0);
        @(negedge clk) reset_n = 1'b1;
        repeat (5) @(posedge clk);

        send_frame(8'h1C, 0, 11);
        @(negedge clk);
        chk("1c_dsr", dsr, 1);
        pop();
        chk("1c_q", q, 8'h1C);
        chk("1c_dsr_after", dsr, 0);
        chk("1c_ferr", ferr_cnt, 0);

        send_frame(8'hF0, 1, 11);
        @(negedge clk);
        chk("par_ferr", ferr_cnt, 1);
        chk("par_dsr", dsr, 0);

        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 11);
        @(negedge clk);
        chk("ovf_set", overflow, 1);
        for (int i = 1; i <= 8; i++) begin
            pop();
            chk($sformatf("ovf_pop%0d", i), q, 32'(i));
        end
        @(negedge clk);
        chk("ovf_empty", dsr, 0);
        chk("ovf_sticky", overflow, 1);

        ferr_base = ferr_cnt;
        send_frame(8'hA5, 0, 5);
        repeat (TO + 50) @(posedge clk);
        @(negedge clk);
        chk("to_ferr", ferr_cnt - ferr_base, 1);
        chk("to_dsr", dsr, 0);
        send_frame(8'h5A, 0, 11);
        pop();
        chk("to_next_q", q, 8'h5A);

        ferr_base = ferr_cnt;
        samplen = 1'b0;
        send_frame(8'h12, 0, 11);
        @(negedge clk);
        chk("sen_dsr", dsr, 0);
        chk("sen_ferr", ferr_cnt - ferr_base, 0);
        samplen = 1'b1;
        repeat (5) @(posedge clk);
        send_frame(8'h12, 0, 11);
        pop();
        chk("sen_q", q, 8'h12);
        chk("sen_ferr2", ferr_cnt - ferr_base, 0);

        send_frame(8'h31, 0, 11);
        send_frame(8'h32, 0, 11);
        send_frame(8'h33, 0, 11);
        send_frame(8'h77, 0, 6);
        @(negedge clk);
        chk("pre_rst_dsr", dsr, 1);
        reset_n = 1'b0;
        #1;
        chk("arst_dsr", dsr, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_q", q, 8'h00);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        send_frame(8'h29, 0, 11);
        @(negedge clk);
        chk("post_rst_dsr", dsr, 1);
        pop();
        chk("post_rst_q", q, 8'h29);
        chk("post_rst_empty", dsr, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
